// File: rtl/aes_block_sched.sv
// AES block scheduler.
// Streams a job of 1..16 sixteen-byte blocks from RAM port A through an external AES core
// and writes the results back through RAM port B. Reads, AES processing and writes of one
// block complete strictly before the next block starts, so overlapping source and
// destination ranges behave as a block-by-block in-place transform.
module aes_block_sched #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   nblk,
  input  logic [7:0]   src_base,
  input  logic [7:0]   dst_base,
  input  logic         kdone,
  output logic [7:0]   ram_addra,
  input  logic [7:0]   ram_douta,
  output logic [7:0]   ram_addrb,
  output logic [7:0]   ram_dinb,
  output logic         ram_web,
  output logic [127:0] aes_din,
  output logic         aes_ld,
  input  logic [127:0] aes_dout,
  input  logic         aes_valid,
  output logic         busy,
  output logic         done,
  output logic         err
);

  // Timeout counter holds "cycles since aes_ld"; wide enough to represent TIMEOUT.
  localparam int unsigned TmoW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Abort is taken on the cycle whose successor count would reach TIMEOUT, so the
  // done/err pulse appears exactly TIMEOUT cycles after aes_ld.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWaitKey = 3'd1;
  localparam logic [2:0] StFetch   = 3'd2;
  localparam logic [2:0] StLoad    = 3'd3;
  localparam logic [2:0] StWaitAes = 3'd4;
  localparam logic [2:0] StStore   = 3'd5;
  localparam logic [2:0] StNext    = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [3:0]      nblk_q;
  logic [7:0]      src_q;
  logic [7:0]      dst_q;
  logic [3:0]      blk_q, blk_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [127:0]    din_q;
  logic [127:0]    res_q;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            latch_job;
  logic            res_ld;
  logic [3:0]      cap_idx;

  // Byte arriving this cycle belongs to the address issued one cycle earlier;
  // at cnt_q == 16 the low nibble is 0 and the subtraction wraps to byte 15.
  assign cap_idx = cnt_q[3:0] - 4'd1;

  // Next-state and sequencing decisions.
  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    err_d     = err_q;
    latch_job = 1'b0;
    res_ld    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch_job = 1'b1;
          err_d     = 1'b0;
          blk_d     = 4'd0;
          cnt_d     = 5'd0;
          state_d   = StWaitKey;
        end
      end
      StWaitKey: begin
        if (kdone) begin
          cnt_d   = 5'd0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // cnt 0..15 issue addresses, cnt 1..16 capture bytes: 17 cycles in total.
        if (cnt_q == 5'd16) begin
          cnt_d   = 5'd0;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StLoad: begin
        tmo_d   = TmoW'(1);
        state_d = StWaitAes;
      end
      StWaitAes: begin
        if (aes_valid) begin
          res_ld  = 1'b1;
          cnt_d   = 5'd0;
          state_d = StStore;
        end else if (tmo_q >= TmoLast) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StStore: begin
        if (cnt_q == 5'd15) begin
          cnt_d   = 5'd0;
          state_d = StNext;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StNext: begin
        if (blk_q == nblk_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          blk_d   = blk_q + 4'd1;
          cnt_d   = 5'd0;
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state, counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      blk_q   <= 4'd0;
      cnt_q   <= 5'd0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Job parameters, captured only when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nblk_q <= 4'd0;
      src_q  <= 8'h00;
      dst_q  <= 8'h00;
    end else if (latch_job) begin
      nblk_q <= nblk;
      src_q  <= src_base;
      dst_q  <= dst_base;
    end
  end

  // Input block assembly; held stable from LOAD until the next FETCH overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= '0;
    end else if (state_q == StFetch && cnt_q != 5'd0) begin
      din_q[{cap_idx, 3'b000} +: 8] <= ram_douta;
    end
  end

  // AES result register, loaded only while waiting for the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (res_ld) begin
      res_q <= aes_dout;
    end
  end

  // RAM port drive; addresses are idle at 0x00 outside their active states.
  always_comb begin
    ram_addra = 8'h00;
    ram_addrb = 8'h00;
    ram_dinb  = 8'h00;
    ram_web   = 1'b0;
    // {blk, i} is 16*blk + i; the 8-bit add wraps modulo 256.
    if (state_q == StFetch && !cnt_q[4]) begin
      ram_addra = src_q + {blk_q, cnt_q[3:0]};
    end
    if (state_q == StStore) begin
      ram_web   = 1'b1;
      ram_addrb = dst_q + {blk_q, cnt_q[3:0]};
      ram_dinb  = res_q[{cnt_q[3:0], 3'b000} +: 8];
    end
  end

  assign aes_din = din_q;
  assign aes_ld  = (state_q == StLoad);
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_aes_block_sched.sv
// Bench for aes_block_sched: RAM and AES-core models, a job-level reference model that
// fills expectation queues, and a monitor that checks every DUT output event against them.
module tb_aes_block_sched;

  localparam int unsigned TMO = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   nblk = 4'd0;
  logic [7:0]   src_base = 8'h00;
  logic [7:0]   dst_base = 8'h00;
  logic         kdone = 1'b0;
  logic [7:0]   ram_addra;
  logic [7:0]   ram_douta = 8'h00;
  logic [7:0]   ram_addrb;
  logic [7:0]   ram_dinb;
  logic         ram_web;
  logic [127:0] aes_din;
  logic         aes_ld;
  logic [127:0] aes_dout = '0;
  logic         aes_valid = 1'b0;
  logic         busy;
  logic         done;
  logic         err;

  aes_block_sched #(
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .nblk      (nblk),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .kdone     (kdone),
    .ram_addra (ram_addra),
    .ram_douta (ram_douta),
    .ram_addrb (ram_addrb),
    .ram_dinb  (ram_dinb),
    .ram_web   (ram_web),
    .aes_din   (aes_din),
    .aes_ld    (aes_ld),
    .aes_dout  (aes_dout),
    .aes_valid (aes_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endfunction

  // ---------------- RAM model: 1-cycle read latency, write on port B ----------------
  logic [7:0] mem [256];

  always @(posedge clk) begin
    ram_douta <= mem[ram_addra];
    if (ram_web) mem[ram_addrb] = ram_dinb;
  end

  // ---------------- AES core model: result = ~block after aes_lat cycles ----------------
  int           aes_lat = 10;
  bit           aes_hang = 1'b0;
  bit           junk_en = 1'b1;
  bit           pend = 1'b0;
  int           aes_cnt = 0;
  logic [127:0] aes_blk = '0;

  always @(negedge clk) begin
    aes_valid = 1'b0;
    if (pend) begin
      if (aes_cnt == 1) begin
        aes_valid = 1'b1;
        aes_dout  = ~aes_blk;
        pend      = 1'b0;
      end
      aes_cnt = aes_cnt - 1;
    end else if (junk_en && !aes_ld && $urandom_range(0, 5) == 0) begin
      // Stray result pulses while no block is outstanding must be ignored.
      aes_valid = 1'b1;
      aes_dout  = {4{$urandom}};
    end
    if (aes_ld && !aes_hang) begin
      pend    = 1'b1;
      aes_cnt = aes_lat;
      aes_blk = aes_din;
    end
  end

  // ---------------- Scoreboard queues and monitor ----------------
  logic [127:0] exp_ld [$];
  logic [15:0]  exp_wr [$];
  logic         exp_done [$];
  logic [15:0]  mon_w;
  logic [127:0] mon_b;
  logic         mon_e;
  int           wr_cnt = 0;
  int           ld_cyc = 0;
  int           done_cyc = 0;

  always @(negedge clk) begin
    if (ram_web) begin
      wr_cnt++;
      check("write_expected", 128'(exp_wr.size() != 0), 128'd1);
      if (exp_wr.size() != 0) begin
        mon_w = exp_wr.pop_front();
        check("write_addr", 128'(ram_addrb), 128'(mon_w[15:8]));
        check("write_data", 128'(ram_dinb), 128'(mon_w[7:0]));
      end
    end
    if (aes_ld) begin
      ld_cyc = cyc;
      check("ld_expected", 128'(exp_ld.size() != 0), 128'd1);
      if (exp_ld.size() != 0) begin
        mon_b = exp_ld.pop_front();
        check("aes_din_block", aes_din, mon_b);
      end
    end
    if (done) begin
      done_cyc = cyc;
      check("done_expected", 128'(exp_done.size() != 0), 128'd1);
      if (exp_done.size() != 0) begin
        mon_e = exp_done.pop_front();
        check("err_at_done", 128'(err), 128'(mon_e));
      end
    end
  end

  // Job-level reference: block b reads src+16b.., AES inverts, writes dst+16b..
  // applied block by block to a private copy of memory.
  task automatic model_job(input logic [3:0] nb, input logic [7:0] s, input logic [7:0] d,
                           input bit hang);
    logic [7:0]   m [256];
    logic [127:0] bv;
    logic [7:0]   a;
    int           nblocks;
    for (int i = 0; i < 256; i++) m[i] = mem[i];
    nblocks = hang ? 1 : int'(nb) + 1;
    for (int b = 0; b < nblocks; b++) begin
      for (int i = 0; i < 16; i++) begin
        a = s + 8'(16 * b + i);
        bv[8*i +: 8] = m[a];
      end
      exp_ld.push_back(bv);
      if (!hang) begin
        for (int i = 0; i < 16; i++) begin
          a    = d + 8'(16 * b + i);
          m[a] = ~bv[8*i +: 8];
          exp_wr.push_back({a, m[a]});
        end
      end
    end
    exp_done.push_back(hang);
  endtask

  // Issues one job at a negedge and waits (bounded) for its done pulse.
  task automatic run_job(input logic [3:0] nb, input logic [7:0] s, input logic [7:0] d,
                         input bit hang, input int lat, input int key_delay, input bit poke,
                         output int elapsed);
    int t0;
    int tk;
    bit seen;
    aes_lat  = lat;
    aes_hang = hang;
    junk_en  = !hang;
    tk       = 0;
    if (key_delay > 0) kdone = 1'b0;
    model_job(nb, s, d, hang);
    start    = 1'b1;
    nblk     = nb;
    src_base = s;
    dst_base = d;
    t0       = cyc;
    @(negedge clk);
    start    = 1'b0;
    nblk     = 4'($urandom);
    src_base = 8'($urandom);
    dst_base = 8'($urandom);
    check("err_cleared_on_start", 128'(err), 128'd0);
    if (key_delay > 0) begin
      for (int k = 0; k < key_delay; k++) begin
        check("keywait_busy", 128'(busy), 128'd1);
        check("keywait_no_ld", 128'(aes_ld), 128'd0);
        @(negedge clk);
      end
      kdone = 1'b1;
      tk    = cyc;
    end
    seen = 1'b0;
    for (int k = 0; k < 8000 && !seen; k++) begin
      if (poke && k == 30) begin
        start    = 1'b1;
        nblk     = 4'($urandom);
        src_base = 8'($urandom);
        dst_base = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 128'(seen), 128'd1);
    elapsed = seen ? cyc - t0 : -1;
    if (key_delay > 0) check("keywait_ld_cycle", 128'(ld_cyc), 128'(tk + 18));
    @(negedge clk);
    check("done_one_cycle", 128'(done), 128'd0);
    check("idle_after_done", 128'(busy), 128'd0);
    aes_hang = 1'b0;
    junk_en  = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int el;
    int w0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_aes_ld", 128'(aes_ld), 128'd0);
    check("rst_ram_web", 128'(ram_web), 128'd0);
    check("rst_aes_din", aes_din, 128'd0);
    check("rst_ram_addra", 128'(ram_addra), 128'd0);
    check("rst_ram_addrb", 128'(ram_addrb), 128'd0);
    check("rst_ram_dinb", 128'(ram_dinb), 128'd0);
    rst_n = 1'b1;
    kdone = 1'b1;
    repeat (2) @(negedge clk);

    // Single block, 10-cycle AES.
    run_job(4'd0, 8'h02, 8'h40, 1'b0, 10, 0, 1'b0, el);
    check("single_latency", 128'(el), 128'(2 + 35 + 10));

    // Key expansion still running for 20 cycles.
    run_job(4'd0, 8'h55, 8'hC0, 1'b0, 3, 20, 1'b0, el);

    // Two blocks with source wrapping past 0xFF.
    run_job(4'd1, 8'hF8, 8'h30, 1'b0, 7, 0, 1'b0, el);
    check("wrap_latency", 128'(el), 128'(2 + 2 * (35 + 7)));

    // AES core never answers.
    run_job(4'd2, 8'h10, 8'h80, 1'b1, 1, 0, 1'b0, el);
    check("timeout_latency", 128'(done_cyc - ld_cyc), 128'(TMO));
    check("err_sticky", 128'(err), 128'd1);
    repeat (3) @(negedge clk);
    check("err_still_sticky", 128'(err), 128'd1);

    // Start pulsed mid-job must not disturb it.
    run_job(4'd1, 8'h60, 8'hA0, 1'b0, 5, 0, 1'b1, el);
    check("poke_latency", 128'(el), 128'(2 + 2 * (35 + 5)));

    // Reset after five writes of a block.
    aes_lat = 5;
    model_job(4'd0, 8'h20, 8'hB0, 1'b0);
    while (exp_wr.size() > 5) void'(exp_wr.pop_back());
    void'(exp_done.pop_back());
    w0       = wr_cnt;
    start    = 1'b1;
    nblk     = 4'd0;
    src_base = 8'h20;
    dst_base = 8'hB0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && (wr_cnt - w0) < 5; k++) begin
      @(negedge clk);
      #1;
    end
    check("rst_mid_writes_seen", 128'(wr_cnt - w0), 128'd5);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_web", 128'(ram_web), 128'd0);
    check("rst_mid_busy", 128'(busy), 128'd0);
    check("rst_mid_done", 128'(done), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_mid_stays_idle", 128'(busy), 128'd0);
    check("rst_mid_no_more_writes", 128'(wr_cnt - w0), 128'd5);

    // Randomised jobs.
    for (int j = 0; j < 6; j++) begin
      logic [3:0] nb;
      int         lat;
      nb  = 4'($urandom_range(0, 3));
      lat = int'($urandom_range(1, 20));
      run_job(nb, 8'($urandom), 8'($urandom), 1'b0, lat, 0, 1'b0, el);
      check("rand_latency", 128'(el), 128'(2 + (int'(nb) + 1) * (35 + lat)));
    end

    repeat (5) @(negedge clk);
    check("wr_queue_drained", 128'(exp_wr.size()), 128'd0);
    check("ld_queue_drained", 128'(exp_ld.size()), 128'd0);
    check("done_queue_drained", 128'(exp_done.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_block_sched.md
AES_BLOCK_SCHED -- requirements
Module: aes_block_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for aes_valid after aes_ld.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to process a job.
REQ-005 SHALL have port nblk  input  4  blocks in job minus 1 (0 = 1 block, 15 = 16 blocks), sampled on accepted start.
REQ-006 SHALL have port src_base  input  8  RAM byte address of first input byte, sampled on accepted start.
REQ-007 SHALL have port dst_base  input  8  RAM byte address of first output byte, sampled on accepted start.
REQ-008 SHALL have port kdone  input  1  AES key expansion complete (level).
REQ-009 SHALL have port ram_addra  output  8  RAM read address, port A.
REQ-010 SHALL have port ram_douta  input  8  RAM read data, valid exactly 1 cycle after ram_addra.
REQ-011 SHALL have ports ram_addrb  output  8, ram_dinb  output  8, ram_web  output  1  RAM write port B (write when ram_web=1).
REQ-012 SHALL have ports aes_din  output  128, aes_ld  output  1  block to AES core, ld one-cycle pulse.
REQ-013 SHALL have ports aes_dout  input  128, aes_valid  input  1  AES result, valid when aes_valid=1.
REQ-014 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse), err  output  1 (sticky until next accepted start).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_KEY, FETCH, LOAD, WAIT_AES, STORE, NEXT.
REQ-016 IDLE: start=1 SHALL be accepted, latch nblk/src_base/dst_base, clear err and block index blk, go WAIT_KEY; busy=1 in every state except IDLE.
REQ-017 start while busy=1 SHALL be ignored, no effect on the job in progress.
REQ-018 WAIT_KEY: SHALL stay until kdone=1, then go FETCH; kdone is not rechecked later in the job.
REQ-019 FETCH: SHALL drive ram_addra = src_base + 16*blk + i for i = 0..15 on 16 consecutive cycles; address arithmetic mod 256 (wrap 0xFF->0x00).
REQ-020 FETCH: byte read at index i SHALL be captured into aes_din[8i+7:8i] the cycle after its address; after byte 15 is captured go LOAD (FETCH occupies 17 cycles).
REQ-021 LOAD: aes_ld SHALL be 1 for exactly one cycle with aes_din holding the complete block, then go WAIT_AES; aes_din SHALL stay stable until next FETCH.
REQ-022 WAIT_AES: on aes_valid=1 SHALL capture aes_dout into internal result register and go STORE; aes_valid outside WAIT_AES SHALL be ignored.
REQ-023 WAIT_AES: timeout counter SHALL count cycles from entry; when it reaches TIMEOUT without aes_valid, SHALL set err=1, pulse done, go IDLE (job aborted, no writes for that block).
REQ-024 STORE: for i = 0..15 on 16 consecutive cycles SHALL drive ram_web=1, ram_addrb = dst_base + 16*blk + i (mod 256), ram_dinb = result[8i+7:8i]; ram_web=0 in all other states.
REQ-025 NEXT: if blk == latched nblk SHALL pulse done and go IDLE, else blk+1 and go FETCH (no WAIT_KEY revisit).
REQ-026 Per-block latency: 17 (FETCH) + 1 (LOAD) + AES latency + 16 (STORE) + 1 (NEXT) cycles.
REQ-027 done SHALL be 1 for exactly one cycle per accepted job, coincident with the return to IDLE; err valid when done=1.
REQ-028 Overlapping src/dst ranges SHALL not be detected; block read always completes before its write.

Reset
REQ-029 On rst_n=0, state SHALL go IDLE immediately; busy, done, err, aes_ld, ram_web = 0; aes_din, counters, blk = 0; ram_addra, ram_addrb, ram_dinb = 0x00.
REQ-030 Reset mid-job SHALL abort the job with no further RAM writes; after release the block waits for a new start.

Verification
REQ-031 Single block: kdone=1, src_base=0x02, dst_base=0x40, nblk=0, AES model returns ~din after 10 cycles -> ram_addra 0x02..0x11, one aes_ld, writes 0x40..0x4F with inverted bytes, done once, err=0.
REQ-032 Key wait: start with kdone=0 for 20 cycles -> no ram_addra activity and no aes_ld until cycle after kdone rises; busy=1 throughout.
REQ-033 Multi-block wrap: src_base=0xF8, nblk=1 -> reads 0xF8..0xFF,0x00..0x07 then 0x08..0x17; two aes_ld; done after second STORE.
REQ-034 Timeout: AES model never asserts aes_valid, TIMEOUT=255 -> err=1 and done pulse 255 cycles after aes_ld, ram_web never 1.
REQ-035 Start during busy and reset mid-STORE: second start ignored (job parameters unchanged); rst_n low after 5 writes -> ram_web=0 at once, no done, IDLE after release.
